// File: rtl/fifo_lvl.sv
// Single-clock show-ahead FIFO, any depth >= 2, with occupancy level and programmable almost flags.
// Define FIFO_LVL_ERR_EN to build the sticky overflow/underflow error registers.
module fifo_lvl #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 8,
    parameter int unsigned LvlW  = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] data_in,
    input  logic             push,
    input  logic             pop,
    output logic [Width-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    input  logic [LvlW-1:0]  af_thresh,
    input  logic [LvlW-1:0]  ae_thresh,
    output logic [LvlW-1:0]  level,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int unsigned PtrW    = $clog2(Depth);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  w_ptr;
    logic [PtrW-1:0]  r_ptr;
    logic             push_acc;
    logic             pop_acc;

    // Requests are accepted only against the registered level, so full/empty
    // block write-through and bypass.
    always_comb begin
        push_acc = push & ~full;
        pop_acc  = pop & ~empty;
    end

    // Pointers and level; pointers wrap by explicit compare for arbitrary depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            level <= '0;
        end else begin
            if (push_acc) begin
                w_ptr <= (w_ptr == PtrLast) ? '0 : w_ptr + PtrW'(1);
            end
            if (pop_acc) begin
                r_ptr <= (r_ptr == PtrLast) ? '0 : r_ptr + PtrW'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   level <= level + LvlW'(1);
                2'b01:   level <= level - LvlW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_acc && !reset) begin
            mem[w_ptr] <= data_in;
        end
    end

    always_comb begin
        full         = (level == LvlFull);
        empty        = (level == '0);
        almost_full  = (level >= af_thresh);
        almost_empty = (level <= ae_thresh);
        data_out     = empty ? '0 : mem[r_ptr];
    end

`ifdef FIFO_LVL_ERR_EN
    // Sticky error flags; a new error event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: doc/fifo_lvl.md
# fifo_lvl

Synchronous single-clock FIFO with arbitrary (non-power-of-2) depth, an occupancy count output and run-time programmable almost-full/almost-empty thresholds. Next-generation buffer for the AXI/APB bridge datapaths (request, write-data and response queues). Show-ahead read port: head entry visible on `data_out` without a pop. Optional sticky overflow/underflow error flags for debug and assertion hooks.

## Interface
- `Width`, 32: data word width in bits, >= 1.
- `Depth`, 8: number of entries, any integer >= 2 (not restricted to powers of 2).
- `LvlW`, $clog2(Depth+1): width of level and threshold buses (derived, do not override).

- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  Width  write data.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `data_out`  out  Width  head entry; 0 when empty.
- `full`  out  1  level == Depth.
- `empty`  out  1  level == 0.
- `almost_full`  out  1  level >= af_thresh.
- `almost_empty`  out  1  level <= ae_thresh.
- `af_thresh`  in  LvlW  almost-full threshold, quasi-static.
- `ae_thresh`  in  LvlW  almost-empty threshold, quasi-static.
- `level`  out  LvlW  current occupancy, 0..Depth.
- `overflow`  out  1  sticky: push while full (see Configuration).
- `underflow`  out  1  sticky: pop while empty (see Configuration).
- `clr_err`  in  1  clears `overflow`/`underflow`.

## Operation
- State: storage array `Depth` x `Width` (not reset), `w_ptr`, `r_ptr` (range 0..Depth-1), `level` register.
- Accept rules: `push_acc = push & ~full`; `pop_acc = pop & ~empty`. Rejected requests have no effect on pointers, level or storage.
- Push: `mem[w_ptr] <= data_in`; `w_ptr` advances.
- Pop: `r_ptr` advances.
- Pointer wrap: pointer equal to Depth-1 advances to 0 (explicit compare, not modulo-2^n).
- Level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when non-empty and non-full: both accepted, level unchanged.
- Push and pop while full: only pop accepted (no write-through); level -> Depth-1.
- Push and pop while empty: only push accepted (no bypass); level -> 1; new word visible next cycle.
- Flags are pure decodes of the registered `level` and threshold inputs; no other state.
- `af_thresh` = 0: `almost_full` always 1. `af_thresh` > Depth: never 1. `ae_thresh` >= Depth: `almost_empty` always 1.
- `data_out = empty ? 0 : mem[r_ptr]`.
- Reset: `w_ptr`, `r_ptr`, `level` <- 0; `overflow`, `underflow` <- 0. Reset wins over same-cycle push/pop. Mid-operation reset discards all contents; storage not cleared but unreachable.
- Reset output values: `data_out`=0, `empty`=1, `full`=0, `level`=0, `almost_empty`=1 (any ae_thresh), `almost_full`=(af_thresh==0), `overflow`=`underflow`=0.

## Timing
- Write-to-read latency 1 cycle: word pushed at edge N visible on `data_out` and counted in `level` after edge N.
- Pop at edge N: next entry (or 0 if empty) on `data_out` after edge N.
- All flags update in the cycle following the accepting edge; no combinational path from `push`/`pop` to any output.
- Threshold changes reflect combinationally on almost flags in the same cycle.

## Configuration
- `FIFO_LVL_ERR_EN` defined: `overflow` set on `push & full`, `underflow` set on `pop & empty`; both sticky until `clr_err`. Set takes priority over `clr_err` in the same cycle. Reset clears both.
- Undefined: `overflow`, `underflow` tied to 0, `clr_err` ignored, no error registers synthesised. Ports remain present.

## Test plan
- Depth=5, Width=8: push 0x11..0x15 -> `full`=1, `level`=5; 6th push 0x16 dropped; pop 5 times -> 0x11..0x15 in order, then `empty`=1, `data_out`=0.
- Depth=5: 12 cycles of continuous push+pop from level 2 -> level stays 2, pointers wrap 4->0 twice, data order intact.
- Depth=8, af_thresh=6, ae_thresh=1: fill from 0 -> `almost_empty` deasserts at level 2, `almost_full` asserts at level 6; af_thresh=9 -> `almost_full`=0 even when full.
- Full with push+pop same cycle -> level 7, new data not written; empty with push+pop -> level 1, `data_out`=pushed word next cycle.
- With `FIFO_LVL_ERR_EN`: pop when empty -> `underflow`=1 and held; `clr_err` with coincident push-when-full -> `overflow`=1, `underflow`=0; without macro both stay 0.
- Reset asserted at level 3 with push active -> next cycle level 0, `empty`=1, `data_out`=0, error flags 0.
